// File: rtl/soc_mem_pkg.sv
// ----------------------------------------------------------------------------
// soc_mem_pkg
//
// Purpose:
//   Shared types and constants for the SoC main-memory path: the requester
//   identifier carried through the arbiter's route FIFO, the fixed requester
//   indices, and the OBI request-field bundle.
//
// Contents:
//   SOC_NUM_REQ / SOC_ADDR_WIDTH / SOC_DATA_WIDTH  default sizing
//   req_id_t                                       requester index
//   REQ_ICACHE / REQ_DCACHE / REQ_VPU              requester indices
//   obi_req_t                                      {we, be, addr, wdata}
// ----------------------------------------------------------------------------
package soc_mem_pkg;

    localparam int SOC_NUM_REQ    = 3;
    localparam int SOC_ADDR_WIDTH = 32;
    localparam int SOC_DATA_WIDTH = 32;

    // A single requester still needs one bit to form a legal vector type.
    localparam int REQ_ID_W = (SOC_NUM_REQ > 1) ? $clog2(SOC_NUM_REQ) : 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    localparam req_id_t REQ_ICACHE = req_id_t'(0);
    localparam req_id_t REQ_DCACHE = req_id_t'(1);
    localparam req_id_t REQ_VPU    = req_id_t'(2);

    typedef struct packed {
        logic                        we;
        logic [SOC_DATA_WIDTH/8-1:0] be;
        logic [SOC_ADDR_WIDTH-1:0]   addr;
        logic [SOC_DATA_WIDTH-1:0]   wdata;
    } obi_req_t;

endpackage

// File: rtl/mem_route_fifo.sv
// ----------------------------------------------------------------------------
// mem_route_fifo
//
// Purpose:
//   Synchronous FIFO of requester identifiers. The arbiter pushes the winner
//   of every accepted transaction and pops the head on every response, so
//   the head always names the requester owed the next in-order response.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset (empties the FIFO)
//   push_i    in   write data_i at the tail (ignored when full)
//   data_i    in   requester identifier to store
//   pop_i     in   drop the head entry (ignored when empty)
//   full_o    out  count == DEPTH
//   empty_o   out  count == 0
//   count_o   out  number of stored entries
//   head_o    out  oldest stored identifier
// ----------------------------------------------------------------------------
module mem_route_fifo
    import soc_mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  req_id_t                    data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output req_id_t                    head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    req_id_t           storage_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  wptr_d;
    logic [PTR_W-1:0]  rptr_q;
    logic [PTR_W-1:0]  rptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              doPush;
    logic              doPop;

    // DEPTH is a power of two, so plain increment wraps modulo depth; a
    // single-entry FIFO keeps both pointers pinned at zero.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = storage_q[rptr_q];

    assign doPush = push_i && !full_o;
    assign doPop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (doPush) begin
            wptr_d = nextPtr(wptr_q);
        end
        if (doPop) begin
            rptr_d = nextPtr(rptr_q);
        end
        // Count is tracked separately from the pointers so full and empty
        // are unambiguous when the pointers coincide.
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry contents are only observed through valid pointers, so the array
    // itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            storage_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// ----------------------------------------------------------------------------
// obi_mem_arbiter
//
// Purpose:
//   Pipelined fixed-priority N-to-1 OBI arbiter between the icache (0),
//   dcache (1) and VPU (2) memory ports and the single-port main-memory
//   controller. Index 0 has highest priority. The winner of every accepted
//   transaction is recorded in a route FIFO so in-order responses return to
//   the requester that issued them. At most MAX_OUTSTANDING transactions
//   may be in flight.
//
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   req_req_i / req_gnt_o     per-requester request / grant
//   req_we_i                  per-requester write enable
//   req_be_i, req_addr_i,
//   req_wdata_i               per-requester fields, packed with requester i
//                             in slice [i*W +: W]
//   req_rvalid_o              per-requester response valid
//   req_rdata_o               response data shared by all requesters
//   mem_req_o .. mem_wdata_o  downstream request channel
//   mem_gnt_i                 downstream grant
//   mem_rvalid_i, mem_rdata_i downstream in-order response channel
//   outstanding_o             transactions in flight
//   proto_err_o               sticky: response seen with nothing in flight
// ----------------------------------------------------------------------------
module obi_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_REQ-1:0]                    req_req_i,
    output logic [NUM_REQ-1:0]                    req_gnt_o,
    input  logic [NUM_REQ-1:0]                    req_we_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     req_be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_wdata_i,
    output logic [NUM_REQ-1:0]                    req_rvalid_o,
    output logic [DATA_WIDTH-1:0]                 req_rdata_o,
    output logic                                  mem_req_o,
    input  logic                                  mem_gnt_i,
    output logic                                  mem_we_o,
    output logic [DATA_WIDTH/8-1:0]               mem_be_o,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    input  logic                                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  proto_err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             anyReq;
    req_id_t          winner;
    logic             accept;
    logic             respValid;
    logic             fifoFull;
    logic             fifoEmpty;
    req_id_t          fifoHead;
    logic [CNT_W-1:0] fifoCount;
    logic             protoErr_q;
    logic             protoErr_d;

    // Priority encoder and field mux. Scanning from the top index down lets
    // the lowest requesting index overwrite, so it wins. The choice is
    // recomputed every cycle: an ungranted requester holds its fields, so a
    // higher-priority arrival may legally take over.
    always_comb begin
        anyReq      = 1'b0;
        winner      = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_req_i[i]) begin
                anyReq      = 1'b1;
                winner      = req_id_t'(i);
                mem_we_o    = req_we_i[i];
                mem_be_o    = req_be_i[i*BE_W +: BE_W];
                mem_addr_o  = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // No same-cycle bypass when full: a response popping this cycle frees a
    // slot only from the next cycle on, keeping mem_req_o off the pop path.
    assign mem_req_o = anyReq && !fifoFull && !rst_i;
    assign accept    = mem_req_o && mem_gnt_i;

    always_comb begin
        req_gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (winner == req_id_t'(i))) begin
                req_gnt_o[i] = 1'b1;
            end
        end
    end

    // A response is only routed when something is in flight; otherwise it
    // is a stray and only raises the error flag.
    assign respValid = mem_rvalid_i && !fifoEmpty && !rst_i;

    always_comb begin
        req_rvalid_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (respValid && (fifoHead == req_id_t'(i))) begin
                req_rvalid_o[i] = 1'b1;
            end
        end
    end

    assign req_rdata_o = mem_rdata_i;

    mem_route_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (winner),
        .pop_i   (respValid),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount),
        .head_o  (fifoHead)
    );

    assign outstanding_o = fifoCount;

    assign protoErr_d = protoErr_q || (mem_rvalid_i && fifoEmpty);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            protoErr_q <= 1'b0;
        end else begin
            protoErr_q <= protoErr_d;
        end
    end

    assign proto_err_o = protoErr_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_obi_mem_arbiter
//
// Purpose:
//   Self-checking bench for obi_mem_arbiter. A queue-based model of the
//   in-flight requester list predicts every output each cycle; directed
//   sequences add literal expectations for reset, single read, contention,
//   full back-pressure, stray response and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_obi_mem_arbiter;

    localparam int NUM_REQ = 3;
    localparam int MAX_OUT = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int BE_W    = DW / 8;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic                      clk_i;
    logic                      rst_i;
    logic [NUM_REQ-1:0]        req_req_i;
    logic [NUM_REQ-1:0]        req_gnt_o;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ*BE_W-1:0]   req_be_i;
    logic [NUM_REQ*AW-1:0]     req_addr_i;
    logic [NUM_REQ*DW-1:0]     req_wdata_i;
    logic [NUM_REQ-1:0]        req_rvalid_o;
    logic [DW-1:0]             req_rdata_o;
    logic                      mem_req_o;
    logic                      mem_gnt_i;
    logic                      mem_we_o;
    logic [BE_W-1:0]           mem_be_o;
    logic [AW-1:0]             mem_addr_o;
    logic [DW-1:0]             mem_wdata_o;
    logic                      mem_rvalid_i;
    logic [DW-1:0]             mem_rdata_i;
    logic [CNT_W-1:0]          outstanding_o;
    logic                      proto_err_o;

    int checks   = 0;
    int failures = 0;

    int routeQ[$];
    bit modelErr;

    obi_mem_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .MAX_OUTSTANDING (MAX_OUT),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_req_i     (req_req_i),
        .req_gnt_o     (req_gnt_o),
        .req_we_i      (req_we_i),
        .req_be_i      (req_be_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .req_rvalid_o  (req_rvalid_o),
        .req_rdata_o   (req_rdata_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_be_o      (mem_be_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .outstanding_o (outstanding_o),
        .proto_err_o   (proto_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int firstSet(input logic [NUM_REQ-1:0] r);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs (called just after a rising edge), then wait
    // for the falling edge where outputs are sampled.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] req, input logic gnt,
                                 input logic rv, input logic [DW-1:0] rdata);
        req_req_i    = req;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rdata;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_we_i[i]                 = 1'($urandom_range(0, 1));
            req_be_i[i*BE_W +: BE_W]    = BE_W'($urandom);
            req_addr_i[i*AW +: AW]      = $urandom;
            req_wdata_i[i*DW +: DW]     = $urandom;
        end
        @(negedge clk_i);
    endtask

    // Compare every output against the model, then advance the model to the
    // state it will hold after the coming rising edge.
    task automatic checkOutput();
        int w;
        logic expReq;
        logic [NUM_REQ-1:0] expGnt;
        logic [NUM_REQ-1:0] expRv;
        logic expWe;
        logic [BE_W-1:0] expBe;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        w       = firstSet(req_req_i);
        expReq  = (w >= 0) && (routeQ.size() < MAX_OUT);
        expGnt  = '0;
        expRv   = '0;
        expWe   = 1'b0;
        expBe   = '0;
        expAddr = '0;
        expWdata = '0;
        if (w >= 0) begin
            expWe    = req_we_i[w];
            expBe    = req_be_i[w*BE_W +: BE_W];
            expAddr  = req_addr_i[w*AW +: AW];
            expWdata = req_wdata_i[w*DW +: DW];
            if (expReq && mem_gnt_i) expGnt[w] = 1'b1;
        end
        if (mem_rvalid_i && routeQ.size() > 0) expRv[routeQ[0]] = 1'b1;

        chk("mem_req",     64'(mem_req_o),     64'(expReq));
        chk("req_gnt",     64'(req_gnt_o),     64'(expGnt));
        chk("mem_we",      64'(mem_we_o),      64'(expWe));
        chk("mem_be",      64'(mem_be_o),      64'(expBe));
        chk("mem_addr",    64'(mem_addr_o),    64'(expAddr));
        chk("mem_wdata",   64'(mem_wdata_o),   64'(expWdata));
        chk("req_rvalid",  64'(req_rvalid_o),  64'(expRv));
        chk("req_rdata",   64'(req_rdata_o),   64'(mem_rdata_i));
        chk("outstanding", 64'(outstanding_o), 64'(routeQ.size()));
        chk("proto_err",   64'(proto_err_o),   64'(modelErr));

        if (mem_rvalid_i) begin
            if (routeQ.size() > 0) void'(routeQ.pop_front());
            else modelErr = 1'b1;
        end
        if (expReq && mem_gnt_i) routeQ.push_back(w);
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Directed contention table: requests, grant, response, and the literal
    // grants / response routing / counts expected.
    logic [2:0] cReq [9] = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic       cRv  [9] = '{0, 0, 1, 0, 1, 1, 1, 1, 0};
    logic [2:0] cGnt [9] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [2:0] cRsp [9] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000};
    int         cCnt [9] = '{0, 1, 2, 2, 3, 3, 2, 1, 0};

    initial begin
        modelErr     = 1'b0;
        rst_i        = 1'b1;
        req_req_i    = 3'b111;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = '0;
        req_we_i     = '0;
        req_be_i     = '0;
        req_addr_i   = '0;
        req_wdata_i  = '0;

        // Outputs forced low during reset despite active inputs.
        #3;
        chk("rst_mem_req",     64'(mem_req_o),     64'd0);
        chk("rst_gnt",         64'(req_gnt_o),     64'd0);
        chk("rst_rvalid",      64'(req_rvalid_o),  64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_proto_err",   64'(proto_err_o),   64'd0);
        nextCycle();
        mem_rvalid_i = 1'b0;
        req_req_i    = '0;
        rst_i        = 1'b0;

        // Single dcache read at 0x100, response two cycles later.
        applyStimulus(3'b010, 1'b1, 1'b0, '0);
        req_addr_i[1*AW +: AW] = 32'h100;
        #1;
        chk("rd_addr", 64'(mem_addr_o), 64'h100);
        chk("rd_gnt",  64'(req_gnt_o),  64'b010);
        checkOutput();
        nextCycle();
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        chk("rd_out1", 64'(outstanding_o), 64'd1);
        chk("rd_gnt_once", 64'(req_gnt_o), 64'd0);
        checkOutput();
        nextCycle();
        applyStimulus(3'b000, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("rd_rvalid", 64'(req_rvalid_o), 64'b010);
        chk("rd_rdata",  64'(req_rdata_o),  64'hDEADBEEF);
        checkOutput();
        nextCycle();
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        chk("rd_out0", 64'(outstanding_o), 64'd0);
        checkOutput();
        nextCycle();

        // Contention with responses routing 0,0,0,1,2 and a push/pop at 2.
        for (int c = 0; c < 9; c++) begin
            applyStimulus(cReq[c], 1'b1, cRv[c], $urandom);
            chk($sformatf("cont_gnt[%0d]", c), 64'(req_gnt_o), 64'(cGnt[c]));
            chk($sformatf("cont_rsp[%0d]", c), 64'(req_rvalid_o), 64'(cRsp[c]));
            chk($sformatf("cont_cnt[%0d]", c), 64'(outstanding_o), 64'(cCnt[c]));
            checkOutput();
            nextCycle();
        end

        // Full back-pressure: four accepts, then no request while full, and
        // no bypass in the popping cycle.
        for (int c = 0; c < MAX_OUT; c++) begin
            applyStimulus(3'b001, 1'b1, 1'b0, '0);
            checkOutput();
            nextCycle();
        end
        applyStimulus(3'b001, 1'b1, 1'b0, '0);
        chk("full_cnt",     64'(outstanding_o), 64'd4);
        chk("full_mem_req", 64'(mem_req_o),     64'd0);
        chk("full_gnt",     64'(req_gnt_o),     64'd0);
        checkOutput();
        nextCycle();
        applyStimulus(3'b001, 1'b1, 1'b1, $urandom);
        chk("full_nobypass", 64'(mem_req_o),    64'd0);
        chk("full_rvalid",   64'(req_rvalid_o), 64'b001);
        checkOutput();
        nextCycle();
        applyStimulus(3'b001, 1'b1, 1'b0, '0);
        chk("full_reassert", 64'(mem_req_o), 64'd1);
        chk("full_regnt",    64'(req_gnt_o), 64'b001);
        checkOutput();
        nextCycle();

        // Randomized traffic; responses only while something is in flight.
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(3'($urandom_range(0, 7)),
                          ($urandom_range(0, 9) < 7),
                          (routeQ.size() > 0) && ($urandom_range(0, 9) < 5),
                          $urandom);
            checkOutput();
            nextCycle();
        end

        // Drain, then a stray response.
        for (int c = 0; c < 20 && routeQ.size() > 0; c++) begin
            applyStimulus(3'b000, 1'b0, 1'b1, $urandom);
            checkOutput();
            nextCycle();
        end
        applyStimulus(3'b000, 1'b0, 1'b1, $urandom);
        chk("stray_rvalid", 64'(req_rvalid_o), 64'd0);
        chk("stray_err_pre", 64'(proto_err_o), 64'd0);
        checkOutput();
        nextCycle();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3'b000, 1'b0, 1'b0, '0);
            chk("stray_err_held", 64'(proto_err_o), 64'd1);
            checkOutput();
            nextCycle();
        end

        // Three in flight, then reset asserted between edges.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(3'b001, 1'b1, 1'b0, '0);
            checkOutput();
            nextCycle();
        end
        req_req_i    = 3'b001;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        #2;
        chk("mid_pre_cnt", 64'(outstanding_o), 64'd3);
        rst_i = 1'b1;
        #1;
        chk("mid_mem_req", 64'(mem_req_o),     64'd0);
        chk("mid_gnt",     64'(req_gnt_o),     64'd0);
        chk("mid_rvalid",  64'(req_rvalid_o),  64'd0);
        chk("mid_cnt",     64'(outstanding_o), 64'd0);
        chk("mid_err",     64'(proto_err_o),   64'd0);
        routeQ.delete();
        modelErr = 1'b0;
        nextCycle();
        mem_rvalid_i = 1'b0;
        rst_i        = 1'b0;
        applyStimulus(3'b100, 1'b1, 1'b0, '0);
        chk("post_gnt", 64'(req_gnt_o),     64'b100);
        chk("post_cnt", 64'(outstanding_o), 64'd0);
        chk("post_err", 64'(proto_err_o),   64'd0);
        checkOutput();
        nextCycle();
        applyStimulus(3'b000, 1'b0, 1'b0, '0);
        chk("post_cnt1", 64'(outstanding_o), 64'd1);
        checkOutput();
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
